// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin merge of NUM_S AXI4-Stream slaves onto one master.
// A grant is held from the first beat until the TLAST beat has transferred.
`timescale 1ns/1ps

module axis_rr_arbiter #(
    parameter int NUM_S       = 4,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    parameter int DEST_W      = 4,
    parameter int USER_W      = 1,
    parameter int KEEP_STRB_W = DATA_W / 8,
    localparam int IDX_W      = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
    input  logic                          ACLK,
    input  logic                          ARESET,

    input  logic [NUM_S-1:0]              S_TVALID,
    output logic [NUM_S-1:0]              S_TREADY,
    input  logic [NUM_S*DATA_W-1:0]       S_TDATA,
    input  logic [NUM_S*KEEP_STRB_W-1:0]  S_TSTRB,
    input  logic [NUM_S*KEEP_STRB_W-1:0]  S_TKEEP,
    input  logic [NUM_S-1:0]              S_TLAST,
    input  logic [NUM_S*ID_W-1:0]         S_TID,
    input  logic [NUM_S*DEST_W-1:0]       S_TDEST,
    input  logic [NUM_S*USER_W-1:0]       S_TUSER,

    output logic                          M_TVALID,
    input  logic                          M_TREADY,
    output logic [DATA_W-1:0]             M_TDATA,
    output logic [KEEP_STRB_W-1:0]        M_TSTRB,
    output logic [KEEP_STRB_W-1:0]        M_TKEEP,
    output logic                          M_TLAST,
    output logic [ID_W-1:0]               M_TID,
    output logic [DEST_W-1:0]             M_TDEST,
    output logic [USER_W-1:0]             M_TUSER,

    output logic                          GRANT_VLD,
    output logic [IDX_W-1:0]              GRANT_IDX
);

    // Handshake: a beat moves on any edge where TVALID && TREADY. Valid never
    // depends on ready here: M_TVALID comes from S_TVALID, S_TREADY from M_TREADY.
    // GRANT_VLD is the observable image of the FSM state (1 = BUSY).

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_ptr;
    logic             grant_vld;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    logic             xfer_last;

    // Scan last_ptr+1, last_ptr+2, ... (mod NUM_S); first requester wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_S; k++) begin
            cand = int'(last_ptr) + k;
            if (cand >= NUM_S) begin
                cand = cand - NUM_S;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_vld && S_TVALID[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    // Pass-through of the granted slice; zeros while idle so outputs stay deterministic.
    always_comb begin
        M_TVALID = 1'b0;
        M_TDATA  = '0;
        M_TSTRB  = '0;
        M_TKEEP  = '0;
        M_TLAST  = 1'b0;
        M_TID    = '0;
        M_TDEST  = '0;
        M_TUSER  = '0;
        S_TREADY = '0;
        if (state == BUSY) begin
            for (int i = 0; i < NUM_S; i++) begin
                if (grant_idx == IDX_W'(i)) begin
                    M_TVALID    = S_TVALID[i];
                    M_TDATA     = S_TDATA[i*DATA_W +: DATA_W];
                    M_TSTRB     = S_TSTRB[i*KEEP_STRB_W +: KEEP_STRB_W];
                    M_TKEEP     = S_TKEEP[i*KEEP_STRB_W +: KEEP_STRB_W];
                    M_TLAST     = S_TLAST[i];
                    M_TID       = S_TID[i*ID_W +: ID_W];
                    M_TDEST     = S_TDEST[i*DEST_W +: DEST_W];
                    M_TUSER     = S_TUSER[i*USER_W +: USER_W];
                    S_TREADY[i] = M_TREADY;
                end
            end
        end
    end

    assign xfer_last = M_TVALID && M_TREADY && M_TLAST;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            grant_idx <= '0;
            grant_vld <= 1'b0;
            last_ptr  <= IDX_W'(NUM_S - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_idx <= pick_idx;
                        grant_vld <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Release on the TLAST beat; the next arbitration costs one idle cycle.
                    if (xfer_last) begin
                        last_ptr  <= grant_idx;
                        grant_vld <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant_vld <= 1'b0;
                end
            endcase
        end
    end

    assign GRANT_VLD = grant_vld;
    assign GRANT_IDX = grant_idx;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: directed scenarios plus random traffic,
// every cycle compared against a packet-level round-robin reference model.
`timescale 1ns/1ps

module tb_axis_rr_arbiter;

  localparam int NUM_S  = 4;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int DEST_W = 4;
  localparam int USER_W = 1;
  localparam int KW     = DATA_W / 8;
  localparam int IDX_W  = 2;
  localparam int DEPTH  = 512;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KW-1:0]     strb;
    logic [KW-1:0]     keep;
    logic              last;
    logic [ID_W-1:0]   id;
    logic [DEST_W-1:0] dest;
    logic [USER_W-1:0] user;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic [NUM_S-1:0]        S_TVALID = '0;
  logic [NUM_S-1:0]        S_TREADY;
  logic [NUM_S*DATA_W-1:0] S_TDATA = '0;
  logic [NUM_S*KW-1:0]     S_TSTRB = '0;
  logic [NUM_S*KW-1:0]     S_TKEEP = '0;
  logic [NUM_S-1:0]        S_TLAST = '0;
  logic [NUM_S*ID_W-1:0]   S_TID = '0;
  logic [NUM_S*DEST_W-1:0] S_TDEST = '0;
  logic [NUM_S*USER_W-1:0] S_TUSER = '0;
  logic                    M_TVALID;
  logic                    M_TREADY = 1'b1;
  logic [DATA_W-1:0]       M_TDATA;
  logic [KW-1:0]           M_TSTRB;
  logic [KW-1:0]           M_TKEEP;
  logic                    M_TLAST;
  logic [ID_W-1:0]         M_TID;
  logic [DEST_W-1:0]       M_TDEST;
  logic [USER_W-1:0]       M_TUSER;
  logic                    GRANT_VLD;
  logic [IDX_W-1:0]        GRANT_IDX;

  axis_rr_arbiter #(
    .NUM_S(NUM_S), .DATA_W(DATA_W), .ID_W(ID_W), .DEST_W(DEST_W), .USER_W(USER_W)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA),
    .S_TSTRB(S_TSTRB), .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST),
    .S_TID(S_TID), .S_TDEST(S_TDEST), .S_TUSER(S_TUSER),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
    .M_TSTRB(M_TSTRB), .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST),
    .M_TID(M_TID), .M_TDEST(M_TDEST), .M_TUSER(M_TUSER),
    .GRANT_VLD(GRANT_VLD), .GRANT_IDX(GRANT_IDX)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  beat_t src_mem [NUM_S][DEPTH];
  int    gap_mem [NUM_S][DEPTH];
  int    wr_ptr  [NUM_S];
  int    drv_ptr [NUM_S];
  int    sb_ptr  [NUM_S];
  int    wait_cnt[NUM_S];
  logic  cur_valid[NUM_S];
  logic  s_xfer  [NUM_S];

  int   valid_pct = 100;
  int   ready_pct = 100;
  logic ready_toggle = 1'b0;

  // reference model: packet-level view of who owns the output
  logic m_busy = 1'b0;
  int   m_g = 0;
  int   m_last = NUM_S - 1;

  logic [IDX_W-1:0] exp_q[$];
  logic check_gap = 1'b0;
  logic seen_grant = 1'b0;
  logic prev_gv = 1'b0;
  int   idle_run = 0;
  int   stall_cnt = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic beat_t slave_beat(int i);
    beat_t b;
    b.data = S_TDATA[i*DATA_W +: DATA_W];
    b.strb = S_TSTRB[i*KW +: KW];
    b.keep = S_TKEEP[i*KW +: KW];
    b.last = S_TLAST[i];
    b.id   = S_TID[i*ID_W +: ID_W];
    b.dest = S_TDEST[i*DEST_W +: DEST_W];
    b.user = S_TUSER[i*USER_W +: USER_W];
    return b;
  endfunction

  function automatic beat_t m_beat();
    beat_t b;
    b.data = M_TDATA;
    b.strb = M_TSTRB;
    b.keep = M_TKEEP;
    b.last = M_TLAST;
    b.id   = M_TID;
    b.dest = M_TDEST;
    b.user = M_TUSER;
    return b;
  endfunction

  function automatic int rr_pick(int last, logic [NUM_S-1:0] v);
    for (int k = 1; k <= NUM_S; k++) begin
      if (v[(last + k) % NUM_S]) return (last + k) % NUM_S;
    end
    return -1;
  endfunction

  function automatic logic all_drained();
    for (int i = 0; i < NUM_S; i++) begin
      if (sb_ptr[i] != wr_ptr[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic add_beat(int s, beat_t b, int gap);
    if (wr_ptr[s] < DEPTH) begin
      src_mem[s][wr_ptr[s]] = b;
      gap_mem[s][wr_ptr[s]] = gap;
      wr_ptr[s]++;
    end
  endtask

  task automatic add_pkt(int s, int len, logic [DATA_W-1:0] base, int gap_beat, int gap_len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b = '0;
      b.data = base + DATA_W'(k);
      b.strb = '1;
      b.keep = '1;
      b.id   = ID_W'(s);
      b.last = (k == len - 1);
      add_beat(s, b, (k == gap_beat) ? gap_len : 0);
    end
  endtask

  task automatic add_rand_pkt(int s);
    beat_t b;
    int len;
    len = $urandom_range(6, 1);
    for (int k = 0; k < len; k++) begin
      b.data = $urandom;
      b.strb = KW'($urandom);
      b.keep = KW'($urandom);
      b.id   = ID_W'($urandom);
      b.dest = DEST_W'($urandom);
      b.user = USER_W'($urandom);
      b.last = (k == len - 1);
      add_beat(s, b, ($urandom_range(3) == 0) ? $urandom_range(2, 1) : 0);
    end
  endtask

  task automatic clear_tb();
    m_busy = 1'b0;
    m_g = 0;
    m_last = NUM_S - 1;
    for (int i = 0; i < NUM_S; i++) begin
      wr_ptr[i] = 0;
      drv_ptr[i] = 0;
      sb_ptr[i] = 0;
      wait_cnt[i] = 0;
      cur_valid[i] = 1'b0;
      s_xfer[i] = 1'b0;
    end
    S_TVALID = '0;
    exp_q.delete();
    check_gap = 1'b0;
    seen_grant = 1'b0;
    prev_gv = 1'b0;
    idle_run = 0;
    stall_cnt = 0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    clear_tb();
    repeat (2) @(posedge ACLK);
    #3;
    ARESET = 1'b0;
    @(negedge ACLK);
    #1;
  endtask

  task automatic wait_done(int max_cycles);
    int n;
    n = 0;
    while (!(all_drained() && !m_busy) && n < max_cycles) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    chk("drained", 64'(all_drained()), 64'(1));
  endtask

  // Source models: hold each beat until accepted, optional gaps before a beat.
  beat_t drv_b;
  initial begin
    for (int i = 0; i < NUM_S; i++) begin
      wr_ptr[i] = 0; drv_ptr[i] = 0; sb_ptr[i] = 0;
      wait_cnt[i] = 0; cur_valid[i] = 1'b0; s_xfer[i] = 1'b0;
    end
    forever begin
      @(posedge ACLK);
      #1;
      if (!ARESET) begin
        for (int i = 0; i < NUM_S; i++) begin
          if (s_xfer[i]) begin
            drv_ptr[i]++;
            cur_valid[i] = 1'b0;
            s_xfer[i] = 1'b0;
            wait_cnt[i] = (drv_ptr[i] < wr_ptr[i]) ? gap_mem[i][drv_ptr[i]] : 0;
          end
          if (!cur_valid[i] && drv_ptr[i] < wr_ptr[i]) begin
            if (wait_cnt[i] > 0) wait_cnt[i]--;
            else if ($urandom_range(99) < valid_pct) cur_valid[i] = 1'b1;
          end
          drv_b = (drv_ptr[i] < wr_ptr[i]) ? src_mem[i][drv_ptr[i]] : '0;
          S_TVALID[i]                  = cur_valid[i];
          S_TDATA[i*DATA_W +: DATA_W]  = drv_b.data;
          S_TSTRB[i*KW +: KW]          = drv_b.strb;
          S_TKEEP[i*KW +: KW]          = drv_b.keep;
          S_TLAST[i]                   = drv_b.last;
          S_TID[i*ID_W +: ID_W]        = drv_b.id;
          S_TDEST[i*DEST_W +: DEST_W]  = drv_b.dest;
          S_TUSER[i*USER_W +: USER_W]  = drv_b.user;
        end
        if (ready_toggle) M_TREADY = ~M_TREADY;
        else M_TREADY = ($urandom_range(99) < ready_pct);
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  beat_t            exp_b;
  beat_t            got_b;
  logic             exp_v;
  logic [NUM_S-1:0] exp_rdy;
  int               pick;
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        exp_v   = m_busy && S_TVALID[m_g];
        exp_rdy = '0;
        if (m_busy) exp_rdy[m_g] = M_TREADY;
        exp_b   = m_busy ? slave_beat(m_g) : '0;
        got_b   = m_beat();

        chk("grant_vld", 64'(GRANT_VLD), 64'(m_busy));
        if (m_busy) chk("grant_idx", 64'(GRANT_IDX), 64'(m_g));
        chk("m_tvalid", 64'(M_TVALID), 64'(exp_v));
        chk("s_tready", 64'(S_TREADY), 64'(exp_rdy));
        chk("m_payload", 64'(got_b), 64'(exp_b));

        for (int i = 0; i < NUM_S; i++) s_xfer[i] = exp_rdy[i] && S_TVALID[i];

        if (exp_v && M_TREADY) begin
          chk("sb_avail", 64'(sb_ptr[m_g] < wr_ptr[m_g]), 64'(1));
          if (sb_ptr[m_g] < wr_ptr[m_g]) begin
            chk("sb_beat", 64'(got_b), 64'(src_mem[m_g][sb_ptr[m_g]]));
            sb_ptr[m_g]++;
          end
        end

        if (GRANT_VLD && !M_TVALID) stall_cnt++;
        if (GRANT_VLD && !prev_gv) begin
          if (check_gap && seen_grant) chk("idle_gap", 64'(idle_run), 64'(1));
          seen_grant = 1'b1;
          idle_run = 0;
        end
        if (!GRANT_VLD) idle_run++;
        prev_gv = GRANT_VLD;

        // advance the model to the state it must hold after the coming edge
        if (m_busy) begin
          if (exp_v && M_TREADY && exp_b.last) begin
            m_busy = 1'b0;
            m_last = m_g;
          end
        end else begin
          pick = rr_pick(m_last, S_TVALID);
          if (pick >= 0) begin
            m_busy = 1'b1;
            m_g = pick;
            if (exp_q.size() > 0) chk("grant_order", 64'(pick), 64'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    clear_tb();
    do_reset();

    // reset values
    chk("rst_grant_vld", 64'(GRANT_VLD), 64'(0));
    chk("rst_grant_idx", 64'(GRANT_IDX), 64'(0));
    chk("rst_m_tvalid", 64'(M_TVALID), 64'(0));
    chk("rst_s_tready", 64'(S_TREADY), 64'(0));
    chk("rst_m_tlast", 64'(M_TLAST), 64'(0));
    chk("rst_m_tdata", 64'(M_TDATA), 64'(0));

    // single packet from S1
    add_pkt(1, 3, 32'hA0, -1, 0);
    @(negedge ACLK); #1;
    chk("t1_latency_vld", 64'(GRANT_VLD), 64'(0));
    @(negedge ACLK); #1;
    chk("t1_grant_vld", 64'(GRANT_VLD), 64'(1));
    chk("t1_grant_idx", 64'(GRANT_IDX), 64'(1));
    chk("t1_beat0", 64'(M_TDATA), 64'hA0);
    chk("t1_last0", 64'(M_TLAST), 64'(0));
    @(negedge ACLK); #1;
    chk("t1_beat1", 64'(M_TDATA), 64'hA1);
    @(negedge ACLK); #1;
    chk("t1_beat2", 64'(M_TDATA), 64'hA2);
    chk("t1_last2", 64'(M_TLAST), 64'(1));
    @(negedge ACLK); #1;
    chk("t1_release", 64'(GRANT_VLD), 64'(0));
    wait_done(50);

    // round-robin fairness with all four slaves busy
    do_reset();
    check_gap = 1'b1;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < NUM_S; s++) add_pkt(s, 2, DATA_W'(32'h100 * s + 32'h10 * p), -1, 0);
    wait_done(500);
    chk("t2_order_done", 64'(exp_q.size()), 64'(0));
    check_gap = 1'b0;

    // no interleave under toggling backpressure
    do_reset();
    ready_toggle = 1'b1;
    exp_q = '{2'd0, 2'd2};
    add_pkt(0, 4, 32'hC00, -1, 0);
    add_pkt(2, 4, 32'hC20, -1, 0);
    wait_done(200);
    chk("t3_order_done", 64'(exp_q.size()), 64'(0));
    ready_toggle = 1'b0;
    M_TREADY = 1'b1;

    // granted S3 stalls mid-packet while S0 waits
    do_reset();
    exp_q = '{2'd3, 2'd0};
    add_pkt(3, 4, 32'hD30, 1, 5);
    for (int n = 0; n < 20 && !GRANT_VLD; n++) @(negedge ACLK);
    #1;
    chk("t4_s3_granted", 64'(GRANT_VLD), 64'(1));
    add_pkt(0, 2, 32'hD00, -1, 0);
    wait_done(200);
    chk("t4_stall_cycles", 64'(stall_cnt), 64'(5));
    chk("t4_order_done", 64'(exp_q.size()), 64'(0));

    // sideband pass-through
    do_reset();
    begin
      beat_t b;
      b.data = 32'h5A5A0001; b.strb = 4'b1111; b.keep = 4'b0111;
      b.id = 4'd5; b.dest = 4'd9; b.user = 1'b1; b.last = 1'b1;
      add_beat(2, b, 0);
    end
    @(negedge ACLK); #1;
    @(negedge ACLK); #1;
    chk("t5_keep", 64'(M_TKEEP), 64'(4'b0111));
    chk("t5_id", 64'(M_TID), 64'(5));
    chk("t5_dest", 64'(M_TDEST), 64'(9));
    chk("t5_user", 64'(M_TUSER), 64'(1));
    chk("t5_data", 64'(M_TDATA), 64'h5A5A0001);
    wait_done(50);

    // asynchronous reset during beat 2 of 4
    do_reset();
    add_pkt(1, 4, 32'hB0, -1, 0);
    @(negedge ACLK); #1;
    @(negedge ACLK); #1;
    @(posedge ACLK); #3;
    chk("t6_pre_valid", 64'(M_TVALID), 64'(1));
    chk("t6_pre_data", 64'(M_TDATA), 64'hB1);
    ARESET = 1'b1;
    #1;
    chk("t6_rst_m_tvalid", 64'(M_TVALID), 64'(0));
    chk("t6_rst_s_tready", 64'(S_TREADY), 64'(0));
    chk("t6_rst_grant_vld", 64'(GRANT_VLD), 64'(0));
    chk("t6_rst_m_tdata", 64'(M_TDATA), 64'(0));
    clear_tb();
    repeat (2) @(posedge ACLK);
    #3;
    ARESET = 1'b0;
    @(negedge ACLK); #1;
    exp_q = '{2'd0, 2'd1, 2'd3};
    add_pkt(3, 1, 32'hE3, -1, 0);
    add_pkt(1, 1, 32'hE1, -1, 0);
    add_pkt(0, 1, 32'hE0, -1, 0);
    wait_done(100);
    chk("t6_order_done", 64'(exp_q.size()), 64'(0));

    // randomized traffic with random valid/ready
    do_reset();
    valid_pct = 70;
    ready_pct = 60;
    for (int p = 0; p < 80; p++) add_rand_pkt($urandom_range(NUM_S - 1));
    wait_done(20000);
    valid_pct = 100;
    ready_pct = 100;
    repeat (3) @(negedge ACLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter that merges NUM_S AXI4-Stream slave ports onto one AXI4-Stream master port.
- A grant is held from the first beat of a packet until the TLAST beat completes, so packets are never interleaved.
- Sits between multiple stream producers and a shared downstream sink, e.g. a DMA engine or an output FIFO.
- All TDATA/TKEEP/TSTRB/TID/TDEST/TUSER sideband is passed through unmodified.

Parameters:
- NUM_S, 4, number of slave ports (2..16).
- DATA_W, 32, TDATA width in bits; multiple of 8.
- ID_W, 4, TID width.
- DEST_W, 4, TDEST width.
- USER_W, 1, TUSER width.
- KEEP_STRB_W, DATA_W/8, derived; TKEEP/TSTRB width; not to be overridden.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_TVALID  in  NUM_S  per-slave valid.
- S_TREADY  out  NUM_S  per-slave ready.
- S_TDATA  in  NUM_S*DATA_W  slave data; slice i = bits [i*DATA_W +: DATA_W].
- S_TSTRB  in  NUM_S*KEEP_STRB_W  slave strobe.
- S_TKEEP  in  NUM_S*KEEP_STRB_W  slave keep.
- S_TLAST  in  NUM_S  slave last.
- S_TID  in  NUM_S*ID_W  slave id.
- S_TDEST  in  NUM_S*DEST_W  slave dest.
- S_TUSER  in  NUM_S*USER_W  slave user.
- M_TVALID  out  1  master valid.
- M_TREADY  in  1  master ready.
- M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER  out  widths as per slice  master payload.
- GRANT_VLD  out  1  a packet is currently granted.
- GRANT_IDX  out  $clog2(NUM_S)  index of the granted slave; valid only when GRANT_VLD=1.

Behaviour:
- Reset (ARESET=1, asynchronous):
  - state=IDLE, GRANT_VLD=0, GRANT_IDX=0.
  - last_ptr=NUM_S-1, so slave 0 has first priority after reset.
  - M_TVALID=0, S_TREADY=all 0.
  - M_TLAST=0; all other M_* payload outputs are 0.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - M_TVALID=0, S_TREADY=0.
  - If any S_TVALID=1, pick the first asserted index scanning last_ptr+1, last_ptr+2, ... modulo NUM_S.
  - Register the pick into GRANT_IDX, set GRANT_VLD=1, and go to BUSY.
  - If no S_TVALID is asserted, stay in IDLE.
  - Arbitration latency is 1 cycle: a request seen at edge k is forwarded from cycle k+1.
- BUSY, with g = GRANT_IDX:
  - Combinational pass-through: M_TVALID=S_TVALID[g], M_* payload = slice g, S_TREADY[g]=M_TREADY.
  - S_TREADY for every other slave = 0.
- Transfer rules:
  - A beat transfers when M_TVALID && M_TREADY.
  - On a transfer with M_TLAST=1: set last_ptr=g, GRANT_VLD=0, and return to IDLE on the same edge.
  - Back-to-back packets therefore have a 1-cycle bubble.
- Non-granted slaves are fully stalled. Their TVALID is unaffected, and they hold their data per AXI-Stream rules.
- The granted slave dropping TVALID mid-packet is legal. Hold the grant; M_TVALID follows it low.
- No combinational path from M_TREADY to M_TVALID, and none from S_TVALID to S_TREADY.
- Single requester: the same slave is re-granted each time, with a 1-cycle IDLE gap between packets.
- Simultaneous requests: strict round-robin order from last_ptr+1. No slave waits more than NUM_S-1 packets.
- Payload while M_TVALID=0: M_* outputs are don't-care but must be deterministic. They show slice g in BUSY and zeros in IDLE.
- Reset mid-packet: outputs go to reset values immediately. The partial packet is abandoned; it is upstream's responsibility to flush.
- TSTRB, TKEEP, TID, TDEST and TUSER are not inspected; they are only forwarded.

Test Plan:
- Single packet: after reset, S1 sends 3 beats (0xA0, 0xA1, 0xA2; TLAST on the third), M_TREADY=1 → GRANT_IDX=1 one cycle after S_TVALID[1] rises; M sees 0xA0..0xA2 with TLAST on the third beat; GRANT_VLD=0 the cycle after.
- Round-robin fairness: S0..S3 all hold valid with 2-beat packets continuously → grant order 0,1,2,3,0,1; each packet followed by exactly 1 idle cycle.
- No interleave under backpressure: S0 and S2 request, M_TREADY toggles 1,0,1,0 → all 4 beats of S0's packet precede S2's; S_TREADY[2]=0 throughout S0's packet; no beat lost or duplicated.
- Mid-packet gap: granted S3 drops TVALID for 5 cycles between beats 1 and 2 while S0 requests → grant stays on 3 and M_TVALID=0 for those 5 cycles; S0 is granted only after S3's TLAST beat.
- Sideband pass-through: S2 sends TKEEP=4'b0111, TID=5, TDEST=9, TUSER=1 → identical values appear on M_* for the same beat.
- Async reset mid-packet: ARESET pulses between edges during beat 2 of 4 → M_TVALID, S_TREADY and GRANT_VLD go to 0 without waiting for ACLK; after release, slave 0 has first priority.
